uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 27 ++
 rtl/uart_tx_sched_if.sv | 40 ++++
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler:
// FSM state encoding, requester count and the round-robin pick helper.
package uart_tx_sched_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // The pointer names the preferred requester; it only matters when both are valid.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic               ptr);
        logic [NUM_REQ-1:0] pick;
        if (&valid) begin
            pick = ptr ? 2'b10 : 2'b01;
        end else begin
            pick = valid;
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of the requester FIFO heads and the uart_tx control/status lines
// seen by the scheduler.
interface uart_tx_sched_if;

    // Requester side: reqN_valid means the FIFO head (reqN_data/reqN_last) is
    // present; reqN_ready is a one-cycle pop strobe and the head is consumed
    // at the end of that cycle. uart_tx side: tx_start is accepted only while
    // tx_busy is low; tx_done pulses once when the byte has left the line.
    logic       req0_valid;
    logic       req1_valid;
    logic [7:0] req0_data;
    logic [7:0] req1_data;
    logic       req0_last;
    logic       req1_last;
    logic       req0_ready;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  req0_valid, req1_valid,
        input  req0_data,  req1_data,
        input  req0_last,  req1_last,
        output req0_ready, req1_ready,
        output tx_start,   tx_din,
        input  tx_busy,    tx_done
    );

    modport slave (
        output req0_valid, req1_valid,
        output req0_data,  req1_data,
        output req0_last,  req1_last,
        input  req0_ready, req1_ready,
        input  tx_start,   tx_din,
        output tx_busy,    tx_done
    );

endinterface

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler feeding one uart_tx from two byte FIFOs.
// A grant is held for a whole packet, or until the owner stalls for GAP_TIMEOUT cycles.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int GAP_TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_sched_if.master       bus,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  timeout,
    output state_e                dbg_state
);

    localparam int CNT_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_TIMEOUT - 1);

    state_e               state_q,   state_d;
    logic [NUM_REQ-1:0]   grant_q,   grant_d;
    logic                 ptr_q,     ptr_d;
    logic [7:0]           tx_din_q,  tx_din_d;
    logic                 last_q,    last_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   valid_vec;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic                 sel_valid;
    logic [7:0]           sel_data;
    logic                 sel_last;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};

    // Only the owner's head is ever looked at, so the other requester cannot interleave.
    always_comb begin
        sel_valid = |(grant_q & valid_vec);
        sel_data  = grant_q[1] ? bus.req1_data : bus.req0_data;
        sel_last  = grant_q[1] ? bus.req1_last : bus.req0_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= 1'b0;
            tx_din_q  <= 8'h00;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            tx_din_q  <= tx_din_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        tx_din_d  = tx_din_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        req_ready = '0;
        tx_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|valid_vec) begin
                    grant_d = rr_pick(valid_vec, ptr_q);
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                req_ready = grant_q;
                tx_din_d  = sel_data;
                last_d    = sel_last;
                state_d   = ST_START;
            end

            ST_START: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = ST_WAIT;
                end
            end

            // tx_done is only meaningful here; pulses in other states fall through.
            ST_WAIT: begin
                if (bus.tx_done) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = ~grant_q[1];
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                if (sel_valid) begin
                    state_d = ST_LOAD;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ptr_d     = ~grant_q[1];
                    state_d   = ST_IDLE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.tx_start   = tx_start;
    assign bus.tx_din     = tx_din_q;
    assign grant          = grant_q;
    assign timeout        = timeout_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: FIFO and uart_tx behavioural models, directed scenarios,
// and randomized packet rounds scored against a packet-level round-robin model.
module tb_uart_tx_sched;
    import uart_tx_sched_pkg::*;

    localparam int GAP_T = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if intf();
    logic [1:0] grant;
    logic       timeout;
    state_e     dbg_state;

    uart_tx_sched #(.GAP_TIMEOUT(GAP_T)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (intf),
        .grant     (grant),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // ---------------- environment state ----------------
    logic [8:0] fifo0[$];          // {last, data}
    logic [8:0] fifo1[$];
    logic [8:0] exp_q[$];          // {source, data} in send order
    int         n_checks = 0;
    int         n_errors = 0;

    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
    logic       r0_last = 1'b0, r1_last = 1'b0;
    logic       uart_busy = 1'b0, uart_done = 1'b0;
    logic       force_busy = 1'b0, spur_done = 1'b0;
    int         uart_cnt = 0;
    logic       start_pend = 1'b0;
    logic       pop0_pend = 1'b0, pop1_pend = 1'b0;
    logic [7:0] din_prev = 8'h00;
    logic       ready_prev = 1'b0;
    int         start_cnt = 0, pop_cnt = 0, ready0_cnt = 0, ready1_cnt = 0;
    logic       s_start, s_rd0, s_rd1;
    logic [8:0] s_exp;
    int         model_ptr = 0;

    assign intf.req0_valid = r0_valid;
    assign intf.req1_valid = r1_valid;
    assign intf.req0_data  = r0_data;
    assign intf.req1_data  = r1_data;
    assign intf.req0_last  = r0_last;
    assign intf.req1_last  = r1_last;
    assign intf.tx_busy    = uart_busy | force_busy;
    assign intf.tx_done    = uart_done | spur_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO / uart_tx models and scoreboard (negedge) ----------------
    always @(negedge clk) begin
        s_start = intf.tx_start;
        s_rd0   = intf.req0_ready;
        s_rd1   = intf.req1_ready;
        if (rst) begin
            pop0_pend  = 1'b0;
            pop1_pend  = 1'b0;
            uart_cnt   = 0;
            uart_busy  = 1'b0;
            uart_done  = 1'b0;
            start_pend = 1'b0;
            din_prev   = 8'h00;
            ready_prev = 1'b0;
        end else begin
            check("ready_owner", 32'({s_rd1 & ~grant[1], s_rd0 & ~grant[0]}), 32'h0);
            check("ready_width", 32'((s_rd0 | s_rd1) & ready_prev), 32'h0);
            if (s_start) begin
                start_cnt++;
                check("start_per_pop", 32'(start_cnt), 32'(pop_cnt));
                check("sb_avail", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    s_exp = exp_q.pop_front();
                    check("sb_byte", 32'({grant[1], intf.tx_din}), 32'(s_exp));
                end
            end
            if (s_rd0 | s_rd1) pop_cnt++;
            if (s_rd0) ready0_cnt++;
            if (s_rd1) ready1_cnt++;
            if (intf.tx_din !== din_prev) check("din_stable", 32'(ready_prev), 32'h1);
            din_prev   = intf.tx_din;
            ready_prev = s_rd0 | s_rd1;

            if (pop0_pend && fifo0.size() != 0) fifo0.delete(0);
            if (pop1_pend && fifo1.size() != 0) fifo1.delete(0);
            pop0_pend = s_rd0;
            pop1_pend = s_rd1;

            uart_done = 1'b0;
            if (uart_cnt != 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    uart_busy = 1'b0;
                    uart_done = 1'b1;
                end
            end
            if (start_pend) begin
                uart_busy  = 1'b1;
                uart_cnt   = $urandom_range(1, 5);
                start_pend = 1'b0;
            end
            if (s_start) start_pend = 1'b1;
        end
        r0_valid = (fifo0.size() != 0);
        r1_valid = (fifo1.size() != 0);
        {r0_last, r0_data} = (fifo0.size() != 0) ? fifo0[0] : 9'h000;
        {r1_last, r1_data} = (fifo1.size() != 0) ? fifo1[0] : 9'h000;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_on();
        rst = 1'b1;
        fifo0.delete();
        fifo1.delete();
        exp_q.delete();
        force_busy = 1'b0;
        spur_done  = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_state(input state_e st, input int budget, input string tag);
        int n = 0;
        while (n < budget && dbg_state != st) begin
            tick();
            n++;
        end
        check(tag, 32'(dbg_state == st), 32'h1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && fifo0.size() == 0 && fifo1.size() == 0 &&
                               dbg_state == ST_IDLE && grant == 2'b00)) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'h1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_grant"},   32'(grant), 32'h0);
        check({pfx, "_start"},   32'(intf.tx_start), 32'h0);
        check({pfx, "_din"},     32'(intf.tx_din), 32'h0);
        check({pfx, "_ready"},   32'({intf.req1_ready, intf.req0_ready}), 32'h0);
        check({pfx, "_timeout"}, 32'(timeout), 32'h0);
        check({pfx, "_idle"},    32'(dbg_state == ST_IDLE), 32'h1);
    endtask

    // Packet-level reference: whole packets are granted round-robin, pointer moves past the sender.
    task automatic random_round();
        int         len0[$], len1[$];
        logic [7:0] b0[$], b1[$];
        int         n0, n1, len, w;
        logic [7:0] b;
        n0 = $urandom_range(0, 3);
        n1 = $urandom_range(0, 3);
        for (int p = 0; p < n0; p++) begin
            len = $urandom_range(1, 4);
            len0.push_back(len);
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                b0.push_back(b);
                fifo0.push_back({j == len - 1, b});
            end
        end
        for (int p = 0; p < n1; p++) begin
            len = $urandom_range(1, 4);
            len1.push_back(len);
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                b1.push_back(b);
                fifo1.push_back({j == len - 1, b});
            end
        end
        while (len0.size() != 0 || len1.size() != 0) begin
            if (len0.size() != 0 && len1.size() != 0) w = model_ptr;
            else w = (len0.size() != 0) ? 0 : 1;
            if (w == 0) begin
                len = len0.pop_front();
                repeat (len) exp_q.push_back({1'b0, b0.pop_front()});
            end else begin
                len = len1.pop_front();
                repeat (len) exp_q.push_back({1'b1, b1.pop_front()});
            end
            model_ptr = 1 - w;
        end
        drain(3000, "rnd_drain");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r0_base, s_base, starts, k_to;

        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // single two-byte packet with latency checks
        rst_on();
        rst = 1'b0;
        r0_base = ready0_cnt;
        s_base  = start_cnt;
        fifo0.push_back({1'b0, 8'h41});
        fifo0.push_back({1'b1, 8'h42});
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h42});
        tick();
        check("lat_grant", 32'(grant), 32'h1);
        check("lat_ready", 32'({intf.req1_ready, intf.req0_ready}), 32'h1);
        tick();
        check("lat_start", 32'(intf.tx_start), 32'h1);
        check("lat_din", 32'(intf.tx_din), 32'h41);
        drain(300, "pkt1_drain");
        check("pkt1_starts", 32'(start_cnt - s_base), 32'd2);
        check("pkt1_pops", 32'(ready0_cnt - r0_base), 32'd2);
        check("pkt1_din_last", 32'(intf.tx_din), 32'h42);

        // contention from reset: alternation A0, B0, A0
        rst_on();
        fifo0.push_back({1'b1, 8'hA0});
        fifo0.push_back({1'b1, 8'hA0});
        fifo1.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b0, 8'hA0});
        rst = 1'b0;
        tick();
        check("cont_first_grant", 32'(grant), 32'h1);
        drain(400, "cont_drain");

        // no interleave: 3-byte req0 packet with req1 valid throughout
        rst_on();
        fifo0.push_back({1'b0, 8'hC0});
        fifo0.push_back({1'b0, 8'hC1});
        fifo0.push_back({1'b1, 8'hC2});
        fifo1.push_back({1'b1, 8'hD0});
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b0, 8'hC1});
        exp_q.push_back({1'b0, 8'hC2});
        exp_q.push_back({1'b1, 8'hD0});
        rst = 1'b0;
        drain(500, "nointl_drain");

        // busy hold for 10 cycles after LOAD
        rst_on();
        force_busy = 1'b1;
        fifo1.push_back({1'b1, 8'h55});
        exp_q.push_back({1'b1, 8'h55});
        rst = 1'b0;
        tick();
        check("bh_load_ready", 32'(intf.req1_ready), 32'h1);
        starts = 0;
        repeat (10) begin
            tick();
            if (intf.tx_start) starts++;
        end
        check("bh_hold_low", 32'(starts), 32'h0);
        tick();
        force_busy = 1'b0;
        #1;
        check("bh_start", 32'(intf.tx_start), 32'h1);
        tick();
        check("bh_single", 32'(intf.tx_start), 32'h0);
        drain(200, "bh_drain");

        // gap timeout, spurious done in IDLE, then req0 preferred
        rst_on();
        fifo1.push_back({1'b0, 8'h77});
        exp_q.push_back({1'b1, 8'h77});
        rst = 1'b0;
        wait_state(ST_GAP, 100, "to_gap_entry");
        k_to = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (timeout) begin
                k_to = k;
                break;
            end
        end
        check("to_cycle", 32'(k_to), 32'd8);
        check("to_grant", 32'(grant), 32'h0);
        tick();
        check("to_pulse_width", 32'(timeout), 32'h0);
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("spur_grant", 32'(grant), 32'h0);
        check("spur_start", 32'(intf.tx_start), 32'h0);
        fifo0.push_back({1'b1, 8'hE0});
        fifo1.push_back({1'b1, 8'hE1});
        exp_q.push_back({1'b0, 8'hE0});
        exp_q.push_back({1'b1, 8'hE1});
        tick();
        check("to_pref_req0", 32'(grant), 32'h1);
        drain(300, "to_drain");

        // asynchronous reset while waiting on uart_tx
        rst_on();
        fifo0.push_back({1'b0, 8'h88});
        fifo0.push_back({1'b1, 8'h89});
        exp_q.push_back({1'b0, 8'h88});
        rst = 1'b0;
        wait_state(ST_WAIT, 100, "ar_reach_wait");
        #2;
        rst = 1'b1;
        fifo0.delete();
        exp_q.delete();
        #1;
        check_reset_outputs("ar");
        tick();
        fifo1.push_back({1'b1, 8'h9A});
        exp_q.push_back({1'b1, 8'h9A});
        rst = 1'b0;
        tick();
        check("ar_req1_grant", 32'(grant), 32'h2);
        drain(200, "ar_drain");

        // randomized packet rounds
        rst_on();
        rst = 1'b0;
        model_ptr = 0;
        for (int r = 0; r < 25; r++) begin
            random_round();
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
